// File: rtl/alu_rr_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
package alu_rr_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} arb_state_t;

  localparam int FLAG_W = 4;
  localparam int CNT_W  = 4;

  // Plain-vector state codes so the FSM register stays a simple logic vector
  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_EXEC = EXEC;
  localparam logic [1:0] ST_RESP = RESP;

endpackage

// File: rtl/alu_rr_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the shared ALU.
interface alu_rr_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int OP_W  = 2
);
  import alu_rr_arbiter_pkg::*;

  logic              req0_valid, req1_valid;
  logic              req0_ready, req1_ready;
  logic [WIDTH-1:0]  req0_A, req1_A, req0_B, req1_B;
  logic [OP_W-1:0]   req0_OpCode, req1_OpCode;
  logic              rsp0_valid, rsp1_valid;
  logic              rsp0_ready, rsp1_ready;
  logic [WIDTH-1:0]  rsp_Result;
  logic [FLAG_W-1:0] rsp_Flags;
  logic [WIDTH-1:0]  alu_A, alu_B;
  logic [OP_W-1:0]   alu_OpCode;
  logic [WIDTH-1:0]  alu_Result;
  logic [FLAG_W-1:0] alu_Flags;
  logic              alu_update;
  logic              busy;
  logic              grant_id;

  modport slave (
    input  req0_valid, req1_valid, req0_A, req1_A, req0_B, req1_B,
           req0_OpCode, req1_OpCode, rsp0_ready, rsp1_ready,
           alu_Result, alu_Flags,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid,
           rsp_Result, rsp_Flags, alu_A, alu_B, alu_OpCode,
           alu_update, busy, grant_id
  );

  modport master (
    output req0_valid, req1_valid, req0_A, req1_A, req0_B, req1_B,
           req0_OpCode, req1_OpCode, rsp0_ready, rsp1_ready,
           alu_Result, alu_Flags,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid,
           rsp_Result, rsp_Flags, alu_A, alu_B, alu_OpCode,
           alu_update, busy, grant_id
  );

endinterface

// File: rtl/alu_rr_arbiter_rr.sv
// Two-way round-robin grant picker; prio chooses the winner only on contention.
module alu_rr_arbiter_rr (
  input  logic req0_valid,
  input  logic req1_valid,
  input  logic prio,
  output logic gnt_any,
  output logic gnt_id
);

  always_comb begin
    gnt_any = req0_valid | req1_valid;
    gnt_id  = (req0_valid & req1_valid) ? prio : req1_valid;
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one ALU between two requesters: grant, hold operands for ALU_LAT
// cycles, capture result/flags, return them on the winner's response channel.
module alu_rr_arbiter
  import alu_rr_arbiter_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int OP_W    = 2,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              resetN,
  alu_rr_arbiter_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ALU_LAT - 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  cnt;
  logic              prio;
  logic              gid;
  logic [WIDTH-1:0]  op_a, op_b, res;
  logic [OP_W-1:0]   op_code;
  logic [FLAG_W-1:0] flags;
  logic              gnt_any, gnt_id;
  logic              grant, capture, rsp_ready_sel, handshake;

  alu_rr_arbiter_rr u_rr (
    .req0_valid (bus.req0_valid),
    .req1_valid (bus.req1_valid),
    .prio       (prio),
    .gnt_any    (gnt_any),
    .gnt_id     (gnt_id)
  );

  always_comb begin
    grant         = (state == ST_IDLE) && gnt_any;
    capture       = (state == ST_EXEC) && (cnt == '0);
    rsp_ready_sel = gid ? bus.rsp1_ready : bus.rsp0_ready;
    handshake     = (state == ST_RESP) && rsp_ready_sel;
  end

  // Payload is taken only in the grant cycle; later changes on the request side are ignored
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      prio    <= 1'b0;
      gid     <= 1'b0;
      op_a    <= '0;
      op_b    <= '0;
      op_code <= '0;
      res     <= '0;
      flags   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            state   <= ST_EXEC;
            gid     <= gnt_id;
            cnt     <= CNT_LOAD;
            op_a    <= gnt_id ? bus.req1_A      : bus.req0_A;
            op_b    <= gnt_id ? bus.req1_B      : bus.req0_B;
            op_code <= gnt_id ? bus.req1_OpCode : bus.req0_OpCode;
          end
        end
        ST_EXEC: begin
          if (capture) begin
            state <= ST_RESP;
            res   <= bus.alu_Result;
            flags <= bus.alu_Flags;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (handshake) begin
            state <= ST_IDLE;
            prio  <= ~gid;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Operand regs feed the ALU directly, so its inputs hold their last value outside EXEC
  assign bus.req0_ready = grant & ~gnt_id;
  assign bus.req1_ready = grant &  gnt_id;
  assign bus.alu_A      = op_a;
  assign bus.alu_B      = op_b;
  assign bus.alu_OpCode = op_code;
  assign bus.alu_update = capture;
  assign bus.rsp0_valid = (state == ST_RESP) & ~gid;
  assign bus.rsp1_valid = (state == ST_RESP) &  gid;
  assign bus.rsp_Result = res;
  assign bus.rsp_Flags  = flags;
  assign bus.busy       = (state != ST_IDLE);
  assign bus.grant_id   = gid;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: timestamp-based reference model,
// table-driven single ops, hand-written corner sequences and random traffic.
module tb_alu_rr_arbiter;
  import alu_rr_arbiter_pkg::*;

  localparam int LAT = 1;

  typedef struct {
    logic        who;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  op;
    logic [15:0] res;
  } vec_t;

  logic clk = 1'b0;
  logic resetN;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  alu_rr_arbiter_if #(.WIDTH(16), .OP_W(2)) bus  ();
  alu_rr_arbiter_if #(.WIDTH(16), .OP_W(2)) bus3 ();

  alu_rr_arbiter #(.WIDTH(16), .OP_W(2), .ALU_LAT(LAT)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  alu_rr_arbiter #(.WIDTH(16), .OP_W(2), .ALU_LAT(3)) dut3 (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus3)
  );

  // ALU stubs: combinational add with fixed flags
  assign bus.alu_Result  = bus.alu_A + bus.alu_B;
  assign bus.alu_Flags   = 4'hA;
  assign bus3.alu_Result = bus3.alu_A + bus3.alu_B;
  assign bus3.alu_Flags  = 4'hA;

  always #5 clk = ~clk;

  // Cycle index advances on the active edge so negedge readers see a stable value
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: one op in flight, identified by its grant cycle and payload
  logic        m_inflight = 1'b0;
  logic        m_gid = 1'b0;
  logic        m_prio = 1'b0;
  int          m_gcyc = 0;
  logic [15:0] m_a, m_b;
  logic [1:0]  m_op;
  logic [1:0]  m_v, m_er;

  always @(negedge clk) begin
    if (!resetN) begin
      m_inflight = 1'b0;
      m_prio     = 1'b0;
      checkOutput("rst_busy",     32'(bus.busy), 0);
      checkOutput("rst_rsp",      32'({bus.rsp1_valid, bus.rsp0_valid}), 0);
      checkOutput("rst_grant_id", 32'(bus.grant_id), 0);
      checkOutput("rst_result",   32'(bus.rsp_Result), 0);
      checkOutput("rst_update",   32'(bus.alu_update), 0);
    end else if (!m_inflight) begin
      m_v  = {bus.req1_valid, bus.req0_valid};
      m_er = 2'b00;
      if (m_v == 2'b11) m_er[m_prio] = 1'b1;
      else              m_er = m_v;
      checkOutput("idle_ready",  32'({bus.req1_ready, bus.req0_ready}), 32'(m_er));
      checkOutput("idle_busy",   32'(bus.busy), 0);
      checkOutput("idle_rsp",    32'({bus.rsp1_valid, bus.rsp0_valid}), 0);
      checkOutput("idle_update", 32'(bus.alu_update), 0);
      if (m_er != 2'b00) begin
        m_inflight = 1'b1;
        m_gid      = m_er[1];
        m_gcyc     = cyc;
        m_a        = m_er[1] ? bus.req1_A      : bus.req0_A;
        m_b        = m_er[1] ? bus.req1_B      : bus.req0_B;
        m_op       = m_er[1] ? bus.req1_OpCode : bus.req0_OpCode;
      end
    end else begin
      checkOutput("op_busy",     32'(bus.busy), 1);
      checkOutput("op_no_ready", 32'({bus.req1_ready, bus.req0_ready}), 0);
      checkOutput("op_grant_id", 32'(bus.grant_id), 32'(m_gid));
      if (cyc <= m_gcyc + LAT) begin
        checkOutput("exec_alu_a",  32'(bus.alu_A), 32'(m_a));
        checkOutput("exec_alu_b",  32'(bus.alu_B), 32'(m_b));
        checkOutput("exec_alu_op", 32'(bus.alu_OpCode), 32'(m_op));
        checkOutput("exec_update", 32'(bus.alu_update), 32'(cyc == m_gcyc + LAT));
        checkOutput("exec_rsp",    32'({bus.rsp1_valid, bus.rsp0_valid}), 0);
      end else begin
        checkOutput("resp_valid",  32'({bus.rsp1_valid, bus.rsp0_valid}), m_gid ? 2 : 1);
        checkOutput("resp_result", 32'(bus.rsp_Result), 32'(16'(m_a + m_b)));
        checkOutput("resp_flags",  32'(bus.rsp_Flags), 'hA);
        checkOutput("resp_update", 32'(bus.alu_update), 0);
        if (m_gid ? bus.rsp1_ready : bus.rsp0_ready) begin
          m_prio     = ~m_gid;
          m_inflight = 1'b0;
        end
      end
    end
  end

  task automatic applyStimulus(input logic who, input logic [15:0] a, input logic [15:0] b,
                               input logic [1:0] op, output int gc);
    logic seen;
    seen = 1'b0;
    gc   = -1;
    @(posedge clk); #1;
    if (who) begin
      bus.req1_valid = 1'b1; bus.req1_A = a; bus.req1_B = b; bus.req1_OpCode = op;
    end else begin
      bus.req0_valid = 1'b1; bus.req0_A = a; bus.req0_B = b; bus.req0_OpCode = op;
    end
    for (int k = 0; k < 50 && !seen; k++) begin
      @(negedge clk);
      if (who ? bus.req1_ready : bus.req0_ready) begin
        seen = 1'b1;
        gc   = cyc;
      end
    end
    if (!seen) checkOutput("grant_timeout", 0, 1);
    @(posedge clk); #1;
    if (who) begin
      bus.req1_valid = 1'b0; bus.req1_A = 16'($urandom); bus.req1_B = 16'($urandom);
    end else begin
      bus.req0_valid = 1'b0; bus.req0_A = 16'($urandom); bus.req0_B = 16'($urandom);
    end
  endtask

  task automatic runOp(input logic who, input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] op, input logic [15:0] exp);
    int gc, uc, rc;
    applyStimulus(who, a, b, op, gc);
    uc = -100;
    rc = -100;
    for (int k = 0; k < 20 && rc < 0; k++) begin
      @(negedge clk);
      if (bus.alu_update && uc < 0) uc = cyc;
      if (who ? bus.rsp1_valid : bus.rsp0_valid) begin
        rc = cyc;
        checkOutput("vec_result",   32'(bus.rsp_Result), 32'(exp));
        checkOutput("vec_flags",    32'(bus.rsp_Flags), 'hA);
        checkOutput("vec_grant_id", 32'(bus.grant_id), 32'(who));
      end
    end
    checkOutput("vec_update_lat", 32'(uc - gc), 1);
    checkOutput("vec_rsp_lat",    32'(rc - gc), 2);
    @(negedge clk);
    checkOutput("vec_back_idle", 32'(bus.busy), 0);
  endtask

  vec_t        vecs[5];
  int          order[6];
  int          gcs[6];
  int          n, grants;
  logic        g0, g1, seen;
  logic [15:0] first_res;

  initial begin
    vecs[0] = '{who: 1'b0, a: 16'h0005, b: 16'h0003, op: 2'b00, res: 16'h0008};
    vecs[1] = '{who: 1'b1, a: 16'hFFFF, b: 16'h0001, op: 2'b01, res: 16'h0000};
    vecs[2] = '{who: 1'b0, a: 16'h1234, b: 16'h1111, op: 2'b10, res: 16'h2345};
    vecs[3] = '{who: 1'b1, a: 16'h8000, b: 16'h7FFF, op: 2'b11, res: 16'hFFFF};
    vecs[4] = '{who: 1'b0, a: 16'h00FF, b: 16'h0001, op: 2'b00, res: 16'h0100};

    {bus.req0_valid, bus.req1_valid, bus.rsp0_ready, bus.rsp1_ready} = '0;
    {bus.req0_A, bus.req0_B, bus.req1_A, bus.req1_B} = '0;
    {bus.req0_OpCode, bus.req1_OpCode} = '0;
    {bus3.req0_valid, bus3.req1_valid, bus3.rsp0_ready, bus3.rsp1_ready} = '0;
    {bus3.req0_A, bus3.req0_B, bus3.req1_A, bus3.req1_B} = '0;
    {bus3.req0_OpCode, bus3.req1_OpCode} = '0;
    resetN = 1'b1;
    #2 resetN = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetN = 1'b1;

    $display("[TB] single operations from table");
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    for (int i = 0; i < 5; i++)
      runOp(vecs[i].who, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].res);

    $display("[TB] contention after reset, six alternating grants");
    @(posedge clk); #1 resetN = 1'b0;
    @(posedge clk); #1 resetN = 1'b1;
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    bus.req0_A = 16'($urandom); bus.req0_B = 16'($urandom);
    bus.req1_A = 16'($urandom); bus.req1_B = 16'($urandom);
    n = 0;
    for (int k = 0; k < 60 && n < 6; k++) begin
      @(negedge clk);
      if (bus.req0_ready || bus.req1_ready) begin
        order[n] = int'(bus.req1_ready);
        gcs[n]   = cyc;
        n++;
      end
      @(posedge clk); #1;
      if (n >= 6) begin
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      end
      bus.req0_A = 16'($urandom); bus.req0_B = 16'($urandom); bus.req0_OpCode = 2'($urandom);
      bus.req1_A = 16'($urandom); bus.req1_B = 16'($urandom); bus.req1_OpCode = 2'($urandom);
    end
    checkOutput("alt_count", 32'(n), 6);
    for (int i = 0; i < n; i++) begin
      checkOutput("alt_order", 32'(order[i]), 32'(i % 2));
      if (i > 0) checkOutput("alt_spacing", 32'(gcs[i] - gcs[i-1]), LAT + 2);
    end
    repeat (5) @(posedge clk);

    $display("[TB] stalled response on channel 1");
    #1 bus.rsp1_ready = 1'b0;
    applyStimulus(1'b1, 16'h0102, 16'h0304, 2'b01, n);
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = bus.rsp1_valid;
    end
    checkOutput("stall_rsp_seen", 32'(seen), 1);
    first_res = bus.rsp_Result;
    checkOutput("stall_result", 32'(first_res), 'h0406);
    for (int k = 1; k < 6; k++) begin
      @(posedge clk); #1;
      if (k == 5) bus.rsp1_ready = 1'b1;
      @(negedge clk);
      checkOutput("stall_valid",  32'(bus.rsp1_valid), 1);
      checkOutput("stall_stable", 32'(bus.rsp_Result), 32'(first_res));
      checkOutput("stall_rsp0",   32'(bus.rsp0_valid), 0);
      checkOutput("stall_busy",   32'(bus.busy), 1);
    end
    @(negedge clk);
    checkOutput("stall_released", 32'(bus.rsp1_valid), 0);
    checkOutput("stall_idle",     32'(bus.busy), 0);

    $display("[TB] three-cycle ALU latency");
    @(posedge clk); #1;
    bus3.rsp0_ready = 1'b1;
    bus3.req0_valid = 1'b1; bus3.req0_A = 16'h1111; bus3.req0_B = 16'h2222; bus3.req0_OpCode = 2'b10;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      seen = bus3.req0_ready;
    end
    checkOutput("lat3_grant", 32'(seen), 1);
    @(posedge clk); #1;
    bus3.req0_valid = 1'b0; bus3.req0_A = 16'hDEAD; bus3.req0_B = 16'hBEEF;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checkOutput("lat3_alu_a",  32'(bus3.alu_A), 'h1111);
      checkOutput("lat3_alu_b",  32'(bus3.alu_B), 'h2222);
      checkOutput("lat3_alu_op", 32'(bus3.alu_OpCode), 2);
      checkOutput("lat3_update", 32'(bus3.alu_update), 32'(k == 3));
      checkOutput("lat3_no_rsp", 32'(bus3.rsp0_valid), 0);
    end
    @(negedge clk);
    checkOutput("lat3_rsp_valid",  32'(bus3.rsp0_valid), 1);
    checkOutput("lat3_rsp_result", 32'(bus3.rsp_Result), 'h3333);
    @(negedge clk);
    checkOutput("lat3_idle", 32'(bus3.busy), 0);

    $display("[TB] reset in the middle of an operation");
    bus.rsp0_ready = 1'b1;
    applyStimulus(1'b0, 16'h4444, 16'h1111, 2'b11, n);
    resetN = 1'b0;
    #1;
    checkOutput("midrst_busy",  32'(bus.busy), 0);
    checkOutput("midrst_rsp",   32'({bus.rsp1_valid, bus.rsp0_valid}), 0);
    checkOutput("midrst_alu_a", 32'(bus.alu_A), 0);
    checkOutput("midrst_upd",   32'(bus.alu_update), 0);
    repeat (2) @(posedge clk);
    #1 resetN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput("postrst_no_rsp", 32'({bus.rsp1_valid, bus.rsp0_valid}), 0);
    end
    runOp(1'b1, 16'h0AAA, 16'h0555, 2'b01, 16'h0FFF);

    $display("[TB] random traffic");
    g0 = 1'b0; g1 = 1'b0; grants = 0;
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      if (g0 || (bus.req0_valid && $urandom_range(0, 15) == 0)) bus.req0_valid = 1'b0;
      if (g1 || (bus.req1_valid && $urandom_range(0, 15) == 0)) bus.req1_valid = 1'b0;
      if (!bus.req0_valid && $urandom_range(0, 1) == 1) begin
        bus.req0_valid = 1'b1; bus.req0_A = 16'($urandom); bus.req0_B = 16'($urandom);
        bus.req0_OpCode = 2'($urandom);
      end
      if (!bus.req1_valid && $urandom_range(0, 1) == 1) begin
        bus.req1_valid = 1'b1; bus.req1_A = 16'($urandom); bus.req1_B = 16'($urandom);
        bus.req1_OpCode = 2'($urandom);
      end
      bus.rsp0_ready = ($urandom_range(0, 3) != 0);
      bus.rsp1_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      g0 = bus.req0_ready;
      g1 = bus.req1_ready;
      if (g0 || g1) grants++;
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    repeat (6) @(posedge clk);
    checkOutput("rand_activity", 32'(grants > 20), 1);
    @(negedge clk);
    checkOutput("final_idle", 32'(bus.busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
